// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor.
// Holds the FSM state set and the status counter widths.
package pll_sup_pkg;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [2:0] {
    ST_PD,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAIL
  } state_e;

  function automatic logic [LOSS_W-1:0] sat_inc(
    input logic [LOSS_W-1:0] v
  );
    return (&v) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear on the synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: powerdown pulse, lock qualification,
// timeout retries, lock-loss filtering and fabric reset control.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int PD_CYCLES     = 64,
  parameter int MAX_RETRIES   = 7,
  parameter int LOSS_FILTER   = 4
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               PLL_LOCK,
  input  logic               RETRY_REQ,
  output logic               PLL_POWERDOWN_N,
  output logic               FABRIC_RESET_N,
  output logic               LOCKED,
  output logic               FAIL,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic [LOSS_W-1:0]  LOSS_CNT
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = $clog2(PD_CYCLES + 1);
  localparam int LW = $clog2(LOSS_FILTER + 1);

  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PD_LAST = PW'(PD_CYCLES - 1);
  localparam logic [LW-1:0] LF_LAST = LW'(LOSS_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_e state, state_nxt;

  logic [TW-1:0] to_cnt, to_nxt;
  logic [SW-1:0] st_cnt, st_nxt;
  logic [PW-1:0] pd_cnt, pd_nxt;
  logic [LW-1:0] lf_cnt, lf_nxt;

  logic [RETRY_W-1:0] retry_nxt;
  logic [LOSS_W-1:0]  loss_nxt;

  logic lock_s;
  logic searching;
  logic timeout;

  sync_2ff u_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  assign searching = (state == ST_WAIT_LOCK) ||
                     (state == ST_STABILIZE);
  assign timeout   = searching && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    st_nxt    = st_cnt;
    pd_nxt    = pd_cnt;
    lf_nxt    = lf_cnt;
    retry_nxt = RETRY_CNT;
    loss_nxt  = LOSS_CNT;

    if (RETRY_REQ) begin
      state_nxt = ST_PD;
      pd_nxt    = '0;
      retry_nxt = '0;
    end else if (timeout) begin
      // timeout beats a same-cycle STABILIZE completion
      if (RETRY_CNT == RETRY_MAX) begin
        state_nxt = ST_FAIL;
      end else begin
        state_nxt = ST_PD;
        pd_nxt    = '0;
        retry_nxt = RETRY_CNT + RETRY_W'(1);
      end
    end else begin
      unique case (state)
        ST_PD: begin
          if (pd_cnt == PD_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            to_nxt    = '0;
            pd_nxt    = '0;
          end else begin
            pd_nxt = pd_cnt + PW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          to_nxt = to_cnt + TW'(1);
          if (lock_s) begin
            state_nxt = ST_STABILIZE;
            st_nxt    = '0;
          end
        end
        ST_STABILIZE: begin
          to_nxt = to_cnt + TW'(1);
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            st_nxt    = '0;
          end else if (st_cnt == ST_LAST) begin
            state_nxt = ST_RUN;
            retry_nxt = '0;
            lf_nxt    = '0;
          end else begin
            st_nxt = st_cnt + SW'(1);
          end
        end
        ST_RUN: begin
          if (lock_s) begin
            lf_nxt = '0;
          end else if (lf_cnt == LF_LAST) begin
            state_nxt = ST_PD;
            pd_nxt    = '0;
            lf_nxt    = '0;
            loss_nxt  = sat_inc(LOSS_CNT);
          end else begin
            lf_nxt = lf_cnt + LW'(1);
          end
        end
        ST_FAIL: begin
        end
        default: begin
          state_nxt = ST_PD;
          pd_nxt    = '0;
        end
      endcase
    end
  end

  // outputs are registered decodes of the next state
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state           <= ST_PD;
      to_cnt          <= '0;
      st_cnt          <= '0;
      pd_cnt          <= '0;
      lf_cnt          <= '0;
      RETRY_CNT       <= '0;
      LOSS_CNT        <= '0;
      PLL_POWERDOWN_N <= 1'b0;
      FABRIC_RESET_N  <= 1'b0;
      LOCKED          <= 1'b0;
      FAIL            <= 1'b0;
    end else begin
      state           <= state_nxt;
      to_cnt          <= to_nxt;
      st_cnt          <= st_nxt;
      pd_cnt          <= pd_nxt;
      lf_cnt          <= lf_nxt;
      RETRY_CNT       <= retry_nxt;
      LOSS_CNT        <= loss_nxt;
      PLL_POWERDOWN_N <= (state_nxt == ST_WAIT_LOCK) ||
                         (state_nxt == ST_STABILIZE) ||
                         (state_nxt == ST_RUN);
      FABRIC_RESET_N  <= (state_nxt == ST_RUN);
      LOCKED          <= (state_nxt == ST_RUN);
      FAIL            <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a timeline model predicts
// every output cycle, a monitor compares, plus directed spot checks.
module tb_pll_lock_supervisor;

  localparam int LT  = 100;
  localparam int SC  = 16;
  localparam int PDC = 8;
  localparam int MR  = 2;
  localparam int LF  = 4;

  localparam int M_PD     = 0;
  localparam int M_SEARCH = 1;
  localparam int M_QUAL   = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAILED = 4;

  localparam logic [15:0] K_PWDN  = 16'h8000;
  localparam logic [15:0] K_FRN   = 16'h4000;
  localparam logic [15:0] K_LOCK  = 16'h2000;
  localparam logic [15:0] K_FAIL  = 16'h1000;
  localparam logic [15:0] K_RETRY = 16'h0F00;
  localparam logic [15:0] K_LOSS  = 16'h00FF;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       PLL_LOCK = 1'b0;
  logic       RETRY_REQ = 1'b0;
  logic       PLL_POWERDOWN_N;
  logic       FABRIC_RESET_N;
  logic       LOCKED;
  logic       FAIL;
  logic [3:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  pll_lock_supervisor #(
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .PD_CYCLES     (PDC),
    .MAX_RETRIES   (MR),
    .LOSS_FILTER   (LF)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .PLL_LOCK        (PLL_LOCK),
    .RETRY_REQ       (RETRY_REQ),
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .LOCKED          (LOCKED),
    .FAIL            (FAIL),
    .RETRY_CNT       (RETRY_CNT),
    .LOSS_CNT        (LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pwdn;
    logic       frn;
    logic       locked;
    logic       fail;
    logic [3:0] retry;
    logic [7:0] loss;
  } o_t;

  typedef struct {
    int sc;
    int t;
    o_t o;
  } exp_t;

  typedef struct {
    int          t;
    logic [15:0] mask;
    logic [15:0] val;
  } spot_t;

  exp_t  exp_q[$];
  spot_t spots[$];
  string spot_nm[$];

  bit rstn_w[];
  bit lock_w[];
  bit rq_w[];
  o_t exp_w[];

  int n_chk = 0;
  int n_fail = 0;

  function automatic o_t act();
    return {PLL_POWERDOWN_N, FABRIC_RESET_N, LOCKED, FAIL,
            RETRY_CNT, LOSS_CNT};
  endfunction

  // Timeline model: phases tracked with absolute end/deadline edges.
  function automatic void model();
    int n = lock_w.size();
    int mode = M_PD;
    int pd_end = 0;
    int deadline = 0;
    int q_done = 0;
    int low_start = -1;
    int tries = 0;
    int losses = 0;
    bit ls;
    exp_w = new[n];
    for (int t = 0; t < n; t++) begin
      ls = (t >= 2) && rstn_w[t-1] && rstn_w[t-2] && lock_w[t-2];
      if (!rstn_w[t]) begin
        mode = M_PD; pd_end = t + PDC; tries = 0; losses = 0;
      end else if (rq_w[t]) begin
        mode = M_PD; pd_end = t + PDC; tries = 0;
      end else if ((mode == M_SEARCH || mode == M_QUAL) && t == deadline) begin
        if (tries == MR) mode = M_FAILED;
        else begin
          tries++; mode = M_PD; pd_end = t + PDC;
        end
      end else begin
        case (mode)
          M_PD:
            if (t == pd_end) begin
              mode = M_SEARCH; deadline = t + LT;
            end
          M_SEARCH:
            if (ls) begin
              mode = M_QUAL; q_done = t + SC;
            end
          M_QUAL:
            if (!ls) mode = M_SEARCH;
            else if (t == q_done) begin
              mode = M_RUN; tries = 0; low_start = -1;
            end
          M_RUN:
            if (ls) low_start = -1;
            else begin
              if (low_start < 0) low_start = t;
              if (t - low_start + 1 == LF) begin
                losses = (losses < 255) ? losses + 1 : 255;
                mode = M_PD; pd_end = t + PDC;
              end
            end
          default: ;
        endcase
      end
      exp_w[t] = {mode == M_SEARCH || mode == M_QUAL || mode == M_RUN,
                  mode == M_RUN, mode == M_RUN, mode == M_FAILED,
                  4'(tries), 8'(losses)};
    end
  endfunction

  // Monitor: compares whenever expected or actual outputs move.
  initial begin : mon
    exp_t e;
    o_t a, pa, pe;
    bit first;
    first = 1'b1;
    pa = '0;
    pe = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act();
        if (first || a != pa || e.o != pe) begin
          n_chk++;
          if (a !== e.o) begin
            n_fail++;
            $display("FAIL outputs sc%0d edge%0d: got %h expected %h",
                     e.sc, e.t, a, e.o);
          end
        end
        first = 1'b0;
        pa = a;
        pe = e.o;
      end
    end
  end

  task automatic new_wave(input int n);
    rstn_w = new[n];
    lock_w = new[n];
    rq_w   = new[n];
    for (int t = 0; t < n; t++) begin
      rstn_w[t] = (t != 0);
      lock_w[t] = 1'b0;
      rq_w[t]   = 1'b0;
    end
  endtask

  task automatic lock_from(input int s);
    for (int t = s; t < lock_w.size(); t++) lock_w[t] = 1'b1;
  endtask

  task automatic lock_low(input int a, input int b);
    for (int t = a; t <= b; t++) lock_w[t] = 1'b0;
  endtask

  task automatic add_spot(input int t, input string nm,
                          input logic [15:0] mask,
                          input logic [15:0] val);
    spot_t s;
    s.t = t; s.mask = mask; s.val = val;
    spots.push_back(s);
    spot_nm.push_back(nm);
  endtask

  task automatic run_sc(input int sc);
    logic [15:0] g;
    model();
    for (int t = 0; t < lock_w.size(); t++) begin
      RESET_N   = rstn_w[t];
      PLL_LOCK  = lock_w[t];
      RETRY_REQ = rq_w[t];
      exp_q.push_back('{sc, t, exp_w[t]});
      @(negedge CLK);
      foreach (spots[i]) begin
        if (spots[i].t == t) begin
          n_chk++;
          g = act() & spots[i].mask;
          if (g !== spots[i].val) begin
            n_fail++;
            $display("FAIL %s sc%0d edge%0d: got %h expected %h",
                     spot_nm[i], sc, t, g, spots[i].val);
          end
        end
      end
    end
    spots.delete();
    spot_nm.delete();
  endtask

  task automatic build_rand(input int n);
    int t;
    int len;
    bit lv;
    new_wave(n);
    t = 0;
    lv = 1'b0;
    while (t < n) begin
      if (!lv && $urandom_range(5, 0) == 0) len = $urandom_range(200, 120);
      else len = $urandom_range(60, 1);
      for (int k = 0; k < len && t < n; k++) begin
        lock_w[t] = lv;
        t++;
      end
      lv = !lv;
    end
    for (int i = 1; i < n; i++) begin
      rq_w[i]   = ($urandom_range(199, 0) == 0);
      rstn_w[i] = ($urandom_range(399, 0) != 0);
    end
  endtask

  task automatic build_sat();
    bit lq[$];
    int h;
    for (int i = 0; i < 21; i++) lq.push_back(1'b0);
    for (int it = 0; it < 270; it++) begin
      h = $urandom_range(40, 32) + ((it == 0) ? 20 : 0);
      for (int i = 0; i < h; i++) lq.push_back(1'b1);
      h = $urandom_range(6, 4);
      for (int i = 0; i < h; i++) lq.push_back(1'b0);
    end
    for (int i = 0; i < 40; i++) lq.push_back(1'b1);
    new_wave(lq.size());
    foreach (lq[i]) lock_w[i] = lq[i];
  endtask

  initial begin : stim
    @(negedge CLK);

    // clean bring-up
    new_wave(60);
    lock_from(21);
    add_spot(0, "reset_state", 16'hFFFF, 16'h0000);
    add_spot(7, "pd_low", K_PWDN, 16'h0000);
    add_spot(8, "pd_rise", K_PWDN, K_PWDN);
    add_spot(38, "lock_early", K_LOCK, 16'h0000);
    add_spot(39, "lock_frn", K_LOCK | K_FRN, K_LOCK | K_FRN);
    add_spot(39, "retry_zero", K_RETRY, 16'h0000);
    run_sc(1);

    // no lock ever: retries, FAIL, then software retry
    new_wave(345);
    rq_w[330] = 1'b1;
    add_spot(108, "retry1", K_RETRY | K_PWDN, 16'h0100);
    add_spot(116, "pd2_rise", K_PWDN, K_PWDN);
    add_spot(216, "retry2", K_RETRY | K_PWDN, 16'h0200);
    add_spot(323, "fail_early", K_FAIL, 16'h0000);
    add_spot(324, "fail_set", K_FAIL | K_PWDN | K_RETRY, 16'h1200);
    add_spot(330, "retry_req", K_FAIL | K_RETRY | K_PWDN, 16'h0000);
    run_sc(2);

    // glitch filter, lock loss, relock, reset in RUN
    new_wave(120);
    lock_from(21);
    lock_low(50, 52);
    lock_low(70, 73);
    rstn_w[110] = 1'b0;
    add_spot(54, "short_glitch", K_LOCK, K_LOCK);
    add_spot(74, "pre_loss", K_LOCK, K_LOCK);
    add_spot(75, "loss", K_LOCK | K_FRN | K_LOSS, 16'h0001);
    add_spot(76, "loss_pd", K_PWDN, 16'h0000);
    add_spot(99, "relock_early", K_LOCK, 16'h0000);
    add_spot(100, "relock", K_LOCK, K_LOCK);
    add_spot(110, "reset_run", 16'hFFFF, 16'h0000);
    run_sc(3);

    // lock drop during stabilize
    new_wave(60);
    lock_from(21);
    lock_low(32, 34);
    add_spot(34, "stab_drop", K_LOCK, 16'h0000);
    add_spot(52, "restab_early", K_LOCK, 16'h0000);
    add_spot(53, "restab", K_LOCK, K_LOCK);
    run_sc(4);

    // timeout coincides with stabilize completion
    new_wave(140);
    lock_from(90);
    add_spot(108, "to_wins", K_LOCK | K_RETRY | K_PWDN, 16'h0100);
    add_spot(132, "to_relock_early", K_LOCK, 16'h0000);
    add_spot(133, "to_relock", K_LOCK | K_RETRY, K_LOCK);
    run_sc(5);

    // loss counter saturation
    build_sat();
    add_spot(lock_w.size() - 1, "loss_sat", K_LOSS | K_LOCK, 16'h20FF);
    run_sc(6);

    for (int r = 0; r < 4; r++) begin
      build_rand(500);
      run_sc(7 + r);
    end

    @(negedge CLK);
    @(negedge CLK);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
